// File: rtl/wb_vga_fetch.sv
// Wishbone single-beat read master that streams framebuffer pixels into a show-ahead FIFO for VGA scan-out.
// First strobe 2 clocks after frame_start; reads stall while the FIFO is full or enable is low.
module wb_vga_fetch #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] fb_base,
  input  logic          frame_start,
  input  logic          pix_req,
  output logic [11:0]   pix_data,
  output logic          pix_valid,
  output logic          underrun,
  output logic          bus_err,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, BUS, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          cyc_q;
  logic          done;
  logic [AW-1:0] adr_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] restart_base;
  logic [CW-1:0] word_cnt;
  logic          restart;
  logic          push;
  logic          set_err;
  logic          latch_base;
  logic          last_word;
  logic          fifo_full;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [PW:0]   fifo_cnt, fifo_cnt_nxt, cnt_after_pop;
  logic          pop;
  logic [11:0]   push_dat;
  logic [11:0]   head_nxt;
  logic          unused_dat;

  assign unused_dat = ^wbm_dat_i[31:12];

  assign last_word = (word_cnt == CW'(FRAME_WORDS - 1));
  assign fifo_full = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  // A restart deferred through DRAIN uses the base captured when frame_start arrived.
  assign restart_base = ((state == DRAIN) && !frame_start) ? base_q : fb_base;

  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    push       = 1'b0;
    set_err    = 1'b0;
    latch_base = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          restart   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (enable && !done && !fifo_full) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i || wbm_err_i) begin
          set_err = wbm_err_i;
          if (frame_start) begin
            restart   = 1'b1;
            state_nxt = FETCH;
          end else begin
            push      = 1'b1;
            state_nxt = last_word ? IDLE : FETCH;
          end
        end else if (frame_start) begin
          latch_base = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (wbm_ack_i || wbm_err_i) begin
          set_err   = wbm_err_i;
          restart   = 1'b1;
          state_nxt = FETCH;
        end else if (frame_start) begin
          latch_base = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      base_q   <= '0;
      word_cnt <= '0;
      done     <= 1'b1;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc_q <= (state_nxt == BUS) || (state_nxt == DRAIN);
      if (latch_base) begin
        base_q <= fb_base;
      end
      if (restart) begin
        adr_q    <= restart_base;
        word_cnt <= '0;
        done     <= 1'b0;
      end else if (push) begin
        adr_q    <= adr_q + AW'(4);
        word_cnt <= word_cnt + CW'(1);
        if (last_word) begin
          done <= 1'b1;
        end
      end
      if (set_err) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Pop is qualified by the registered valid, so a push into an empty FIFO is never popped in the same cycle.
  always_comb begin
    pop           = pix_req && pix_valid;
    push_dat      = wbm_err_i ? 12'h000 : wbm_dat_i[11:0];
    rd_ptr_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
    cnt_after_pop = pop ? fifo_cnt - (PW+1)'(1) : fifo_cnt;
    fifo_cnt_nxt  = push ? cnt_after_pop + (PW+1)'(1) : cnt_after_pop;
    head_nxt      = (cnt_after_pop == '0) ? push_dat : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_valid <= 1'b0;
      pix_data  <= 12'h000;
      underrun  <= 1'b0;
    end else if (restart) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_ptr_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      pix_valid <= (fifo_cnt_nxt != '0);
      if (fifo_cnt_nxt != '0) begin
        pix_data <= head_nxt;
      end
      if (pix_req && !pix_valid) begin
        underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;

endmodule

// File: doc/wb_vga_fetch.md
Name: wb_vga_fetch

Overview:
- Wishbone initiator (master) that streams framebuffer pixels from system memory into a small show-ahead pixel FIFO.
- The VGA scan-out logic drains the FIFO one pixel at a time.
- It sits between the LM32 system bus, on the master side of the interconnect, and the VGA timing/pixel path.
- It is the bus-initiating counterpart of the existing VGA register slave.

Parameters:
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, minimum 4.
- FRAME_WORDS, 307200: 32-bit words fetched per frame, one pixel per word.
- AW, 32: Wishbone address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  fetch enable; when 0, no new bus cycles start
- fb_base  in  AW  framebuffer byte base address; word-aligned; sampled at frame_start
- frame_start  in  1  one-cycle pulse at the start of vertical blanking; restarts the frame
- pix_req  in  1  consumer pop strobe
- pix_data  out  12  RGB 4:4:4 at the FIFO head
- pix_valid  out  1  FIFO not empty
- underrun  out  1  sticky: pix_req was seen with the FIFO empty
- bus_err  out  1  sticky: wbm_err_i was seen
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  tied to 0
- wbm_sel_o  out  4  tied to 4'hF
- wbm_adr_o  out  AW  read address
- wbm_dat_i  in  32  read data; pixel in bits [11:0]
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_err_i  in  1  Wishbone error

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE, cyc/stb=0, adr=0, FIFO empty, word count=0, pix_valid=0, pix_data=0, underrun=0, bus_err=0, done=1. Nothing is fetched until the first frame_start.
- Bus cycles are classic single-beat reads only, with at most one cycle in flight.
  - cyc and stb are asserted together and held, with adr stable, until the cycle ends on ack or err.
  - Both drop in the cycle after ack or err.
- FSM states:
  - IDLE: wait for frame_start.
  - FETCH: decide whether to issue a read.
  - BUS: cycle active, waiting for ack/err.
  - DRAIN: cycle active with its data to be discarded.
- IDLE -> FETCH on frame_start. In the same edge: adr<=fb_base, count<=0, FIFO flushed, underrun cleared, done=0.
- FETCH -> BUS when enable=1, done=0, and FIFO occupancy < FIFO_DEPTH.
  - cyc/stb go high in the cycle after the FETCH decision.
  - Latency from frame_start to the first stb is 2 clocks.
- BUS -> FETCH on ack:
  - push wbm_dat_i[11:0] into the FIFO;
  - adr<=adr+4, with AW-bit wrap-around and no saturation;
  - count<=count+1.
  - If count==FRAME_WORDS-1: done=1 and the next state is IDLE.
- BUS on err: same as ack, but push 12'h000 and set bus_err. The fetch continues; no retry.
- frame_start while in BUS: go to DRAIN.
  - The current cycle completes, because the bus protocol must not be abandoned.
  - On its ack/err the data is not pushed.
  - Then apply the restart actions (adr/count/flush/underrun) and enter FETCH.
  - frame_start in FETCH, or with done=1, restarts immediately.
- Overflow is impossible because a read is only issued when at least one FIFO slot is free. This covers the case of push with the FIFO full.
- Simultaneous push and pop:
  - occupancy unchanged;
  - a push into an empty FIFO with pix_req in the same cycle: the pop is ignored and underrun is set.
- FIFO is show-ahead: pix_data = head entry and pix_valid = !empty, both registered.
  - pix_req with pix_valid=1 pops; the next entry is visible in the following cycle.
  - pix_req with pix_valid=0 sets underrun and leaves pix_data at its last value.
- underrun clears only on reset or a frame_start restart. bus_err clears only on reset.
- enable=0 mid-frame:
  - an in-flight cycle completes normally;
  - no further reads start;
  - the address and count are held, and fetching resumes from the same address when enable returns to 1.

Test Plan:
- Reset, then a frame_start pulse with fb_base=32'h0000_1000, FRAME_WORDS=4, zero-wait slave returning 32'h0000_0ABC, then 0x111, 0x222, 0x333; no pix_req -> reads at 0x1000, 0x1004, 0x1008, 0x100C; first stb 2 clocks after frame_start; pix_data=12'hABC with pix_valid=1; FSM returns to IDLE with 4 entries and no 5th cycle.
- FIFO_DEPTH=4, FRAME_WORDS=16, no pix_req -> exactly 4 reads then cyc stays 0. One pix_req -> exactly one further read, at fb_base+16.
- Slave inserts 3 wait states -> cyc/stb/adr stable for 4 cycles; push only on the ack cycle; cyc drops the next cycle.
- frame_start asserted while a read of 0x1008 is waiting on ack -> cycle completes, its data is not pushed, FIFO is empty, and the next read goes to the new fb_base.
- pix_req with the FIFO empty -> underrun=1 and held; the next frame_start clears it.
- Slave answers the 2nd read with wbm_err_i -> bus_err=1; the FIFO entry is 12'h000; the 3rd read proceeds at base+8.
- Reset asserted mid-BUS -> cyc/stb drop immediately (asynchronously); all outputs take their reset values.
